// File: rtl/zero_share_generator.sv
// N-bit zero-sharings (XOR of all bits is 0) from a seeded 32-bit Galois LFSR. ZSG_RANDOMNESS_OFF_EN forces r_out to 0.
// Latency: first r_valid 1 cycle after RUN, then 1/cycle; r_out and LFSR hold while r_valid && !r_ready.
module zero_share_generator #(
    parameter int D             = 2,
    parameter int N             = D + 1,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_valid,
    input  logic [31:0]  seed,
    output logic         seed_ready,
    output logic         r_valid,
    input  logic         r_ready,
    output logic [N-1:0] r_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [31:0] TAPS      = 32'h80200003;
    localparam logic [31:0] ZERO_SEED = 32'hACE1ACE1;
    localparam logic [7:0]  WARM_LAST = 8'(WARMUP_CYCLES - 1);
    localparam state_t      SEED_DEST = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

    state_t         r_state;
    logic [31:0]    r_lfsr;
    logic [7:0]     r_cnt;
    logic           r_vld;
    logic [N-1:0]   r_vec;

    state_t         w_state_nxt;
    logic [31:0]    w_lfsr_nxt;
    logic [7:0]     w_cnt_nxt;
    logic           w_vld_nxt;
    logic [N-1:0]   w_vec_nxt;
    logic [31:0]    w_lfsr_step;
    logic [31:0]    w_seed_fix;
    logic [N-1:0]   w_vec;
    logic [N-1:0]   w_vec_out;

    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 32'h0);
    // An all-zero LFSR would lock up, so a zero seed is substituted
    assign w_seed_fix  = (seed == 32'h0) ? ZERO_SEED : seed;

    generate
        if (N == 1) begin : g_single
            assign w_vec = '0;
        end else begin : g_multi
            assign w_vec = {^r_lfsr[N-2:0], r_lfsr[N-2:0]};
        end
    endgenerate

`ifdef ZSG_RANDOMNESS_OFF_EN
    assign w_vec_out = '0;
`else
    assign w_vec_out = w_vec;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_vld_nxt   = r_vld;
        w_vec_nxt   = r_vec;
        seed_ready  = 1'b1;
        case (r_state)
            IDLE: begin
                if (seed_valid) begin
                    w_lfsr_nxt  = w_seed_fix;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = SEED_DEST;
                end
            end
            WARMUP: begin
                seed_ready = 1'b0;
                w_lfsr_nxt = w_lfsr_step;
                w_cnt_nxt  = r_cnt + 8'd1;
                if (r_cnt == WARM_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // A reseed drops any unaccepted vector; a same-cycle transfer still completes
                if (seed_valid) begin
                    w_lfsr_nxt  = w_seed_fix;
                    w_cnt_nxt   = 8'd0;
                    w_vld_nxt   = 1'b0;
                    w_vec_nxt   = '0;
                    w_state_nxt = SEED_DEST;
                end else if (!r_vld || r_ready) begin
                    w_vec_nxt  = w_vec_out;
                    w_vld_nxt  = 1'b1;
                    w_lfsr_nxt = w_lfsr_step;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_lfsr  <= 32'h0;
            r_cnt   <= 8'd0;
            r_vld   <= 1'b0;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vld   <= w_vld_nxt;
            r_vec   <= w_vec_nxt;
        end
    end

    assign r_valid = r_vld;
    assign r_out   = r_vec;

endmodule

// File: doc/zero_share_generator.md
Name: zero_share_generator

Overview:
- Upstream randomness source for the masked ALU datapath.
- Produces N-bit zero-sharings: XOR of all bits is 0. These feed the port_r input of the masked gadget stage so that XOR-reducing the re-masked operand recovers the unmasked value.
- Bits come from a seeded 32-bit Galois LFSR, delivered over a valid/ready handshake.
- Includes a seed/warm-up state machine and mid-operation reseed.

Parameters:
- D, 2, masking order.
- N, D+1, number of shares, equal to the output width. Constraint: N-1 <= 32.
- WARMUP_CYCLES, 16, LFSR steps discarded after every seed load, range 0..255.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-low (rst==0 at a rising clk edge resets the block).
- seed_valid  input  1  a seed is offered.
- seed  input  32  seed value.
- seed_ready  output  1  the seed is accepted when seed_valid&&seed_ready.
- r_valid  output  1  r_out holds a fresh zero-sharing.
- r_ready  input  1  the consumer accepts r_out when r_valid&&r_ready.
- r_out  output  N  zero-sharing vector.

Behaviour:
- Reset values:
  - state=IDLE, lfsr=0, warm counter=0.
  - r_valid=0, r_out=0, seed_ready=1.
  - Reset overrides every other event in the same cycle.
- LFSR step, one step per cycle: lsb=lfsr[0]; lfsr=lfsr>>1; if lsb, lfsr^=32'h80200003.
- Seed load: lfsr<=seed. A zero seed is replaced by 32'hACE1ACE1 (an all-zero LFSR is forbidden).
- Vector build from the current lfsr:
  - r_out[N-2:0]=lfsr[N-2:0].
  - r_out[N-1]=^lfsr[N-2:0].
  - If N==1, r_out=0.
- FSM:
  - IDLE: seed_ready=1, r_valid=0. On a seed handshake, load the seed, clear the counter, and go to WARMUP. If WARMUP_CYCLES==0, go directly to RUN instead.
  - WARMUP: seed_ready=0, r_valid=0. Step the LFSR each cycle and increment the counter. Go to RUN after the cycle in which counter==WARMUP_CYCLES-1.
  - RUN: seed_ready=1. The output register updates when !r_valid || r_ready. On update, r_out<=vector(lfsr), r_valid<=1, and the LFSR steps. Otherwise the LFSR holds and r_out/r_valid hold (r_out stays stable under back-pressure).
- Latency: the first r_valid rises 1 cycle after entering RUN. After that, sustained throughput is 1 vector/cycle with r_ready held at 1.
- Reseed in RUN (seed handshake):
  - A consumer handshake in the same cycle completes normally.
  - Next cycle: r_valid=0, r_out=0, lfsr=new seed, state=WARMUP (or RUN if WARMUP_CYCLES==0).
  - A pending unaccepted vector is discarded, never delivered.
- seed_valid during WARMUP is ignored: seed_ready=0, no state change.
- The counter is 8 bits wide and never wraps in normal operation (bounded by WARMUP_CYCLES).
- Invariant: ^r_out==0 on every cycle.
- No vector ever repeats across the back-pressure boundary (each vector is emitted exactly once per LFSR step).

Optional Feature:
- Macro: ZSG_RANDOMNESS_OFF_EN.
- Defined: r_out is forced to all zeros. The FSM, LFSR, handshake timing and r_valid are unchanged. This is an unprotected baseline for leakage-analysis comparison runs.
- Undefined: normal LFSR-derived zero-sharings as specified above.

Test Plan:
- Reset: drive rst=0 for 2 cycles, then rst=1 with no seed. Required: r_valid=0, r_out=0, seed_ready=1 indefinitely.
- Seed with WARMUP_CYCLES=0, D=2, seed=32'h00000001, r_ready=1. Required: first vector r_out=3'b101, next 3'b011 (lfsr=32'h80200003), then continuous valid vectors with ^r_out==0 every cycle.
- Default WARMUP_CYCLES=16, seed=32'h12345678. Required: seed_ready=0 for exactly 16 cycles and r_valid first high 1 cycle after entering RUN. A second seed_valid during warm-up is ignored.
- Back-pressure: hold r_ready=0 for 5 cycles with r_valid=1. Required: r_out and lfsr unchanged. On release, the held vector transfers first and the next vector follows the very next cycle.
- Reseed mid-stream: in RUN, assert seed_valid with seed=32'h0 and r_ready=0. Required: next cycle r_valid=0 and lfsr=32'hACE1ACE1; the pending vector is never delivered; RUN resumes after warm-up.
- Reset mid-operation: rst=0 during RUN with r_valid=1. Required: next cycle state=IDLE, r_valid=0, r_out=0, seed_ready=1.
